// File: rtl/apb_decoder_if.sv
// APB master-side port of the request-path decoder.
// Carries the setup/access strobes from the master and the response back.
interface apb_decoder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  m_psel_i;
  logic                  m_penable_i;
  logic [ADDR_WIDTH-1:0] m_paddr_i;
  logic                  m_pwrite_i;
  logic [DATA_WIDTH-1:0] m_pwdata_i;
  logic                  m_pready_o;
  logic [DATA_WIDTH-1:0] m_prdata_o;
  logic                  m_pslverr_o;

  modport master (
    output m_psel_i, m_penable_i, m_paddr_i,
    output m_pwrite_i, m_pwdata_i,
    input  m_pready_o, m_prdata_o, m_pslverr_o
  );

  modport slave (
    input  m_psel_i, m_penable_i, m_paddr_i,
    input  m_pwrite_i, m_pwdata_i,
    output m_pready_o, m_prdata_o, m_pslverr_o
  );
endinterface

// File: rtl/apb_decoder.sv
// APB demux request path: decode, slave SETUP/ACCESS, local error replies.
// Optional slave timeout is enabled with `define APB_DEC_TIMEOUT_EN.
module apb_decoder #(
  parameter int SLAVE_COUNT = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int SLAVE_ADDR_BITS = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   pclk_i,
  input  logic                   preset_i,
  apb_decoder_if.slave           m,
  output logic [SLAVE_COUNT-1:0] sl_psel_o,
  output logic                   sl_penable_o,
  output logic [ADDR_WIDTH-1:0]  sl_paddr_o,
  output logic                   sl_pwrite_o,
  output logic [DATA_WIDTH-1:0]  sl_pwdata_o,
  output logic [SLAVE_COUNT-1:0] select_o,
  input  logic                   mux_pready_i,
  input  logic [DATA_WIDTH-1:0]  mux_prdata_i,
  input  logic                   mux_pslverr_i
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    DECERR
`ifdef APB_DEC_TIMEOUT_EN
    , TOUT
`endif
  } state_t;

  state_t state_q, state_d;

  logic [SLAVE_COUNT-1:0] sel_q;
  logic [ADDR_WIDTH-1:0]  paddr_q;
  logic                   pwrite_q;
  logic [DATA_WIDTH-1:0]  pwdata_q;

  logic [ADDR_WIDTH-1:0]  off;
  logic [ADDR_WIDTH-1:0]  blk;
  logic                   borrow;
  logic [SLAVE_COUNT-1:0] dec_sel;
  logic                   hit;

  logic                   pready;
  logic [DATA_WIDTH-1:0]  prdata;
  logic                   pslverr;
  logic [SLAVE_COUNT-1:0] psel;
  logic                   penable;

  logic unused;
  assign unused = m.m_penable_i ^ (TIMEOUT_CYCLES < 2);

  // Borrow out of the subtraction means the address is below the window.
  always_comb begin
    {borrow, off} = {1'b0, m.m_paddr_i} - {1'b0, BASE_ADDR};
    blk = off >> SLAVE_ADDR_BITS;
    dec_sel = '0;
    for (int i = 0; i < SLAVE_COUNT; i++) begin
      dec_sel[i] = !borrow && (blk == ADDR_WIDTH'(i));
    end
    hit = |dec_sel;
  end

`ifdef APB_DEC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] count_q;

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      count_q <= '0;
    end else if (state_q == SETUP) begin
      count_q <= '0;
    end else if (state_q == ACCESS && !mux_pready_i) begin
      count_q <= count_q + 1'b1;
    end
  end
`endif

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && m.m_psel_i) begin
        sel_q    <= dec_sel;
        paddr_q  <= m.m_paddr_i;
        pwrite_q <= m.m_pwrite_i;
        pwdata_q <= m.m_pwdata_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    psel    = '0;
    penable = 1'b0;
    pready  = 1'b0;
    prdata  = '0;
    pslverr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m.m_psel_i) begin
          state_d = hit ? SETUP : DECERR;
        end
      end
      SETUP: begin
        psel    = sel_q;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel    = sel_q;
        penable = 1'b1;
        pready  = mux_pready_i;
        if (mux_pready_i) begin
          prdata  = mux_prdata_i;
          pslverr = mux_pslverr_i;
          state_d = IDLE;
        end
`ifdef APB_DEC_TIMEOUT_EN
        else if (count_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = TOUT;
        end
`endif
      end
      DECERR: begin
        pready  = 1'b1;
        pslverr = 1'b1;
        state_d = IDLE;
      end
`ifdef APB_DEC_TIMEOUT_EN
      TOUT: begin
        pready  = 1'b1;
        pslverr = 1'b1;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign sl_psel_o     = psel;
  assign select_o      = psel;
  assign sl_penable_o  = penable;
  assign sl_paddr_o    = paddr_q;
  assign sl_pwrite_o   = pwrite_q;
  assign sl_pwdata_o   = pwdata_q;
  assign m.m_pready_o  = pready;
  assign m.m_prdata_o  = prdata;
  assign m.m_pslverr_o = pslverr;

endmodule

// File: tb/tb_apb_decoder.sv
// Directed bench for apb_decoder: vector table plus multi-cycle sequences.
// Covers decode, wait states, decode error, timeout, and reset abort.
module tb_apb_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  sl_psel, select;
  logic        sl_penable, sl_pwrite;
  logic [31:0] sl_paddr, sl_pwdata;
  logic        mux_pready = 1'b0;
  logic [31:0] mux_prdata = '0;
  logic        mux_pslverr = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  apb_decoder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_decoder dut (
    .pclk_i        (clk),
    .preset_i      (rst),
    .m             (bus.slave),
    .sl_psel_o     (sl_psel),
    .sl_penable_o  (sl_penable),
    .sl_paddr_o    (sl_paddr),
    .sl_pwrite_o   (sl_pwrite),
    .sl_pwdata_o   (sl_pwdata),
    .select_o      (select),
    .mux_pready_i  (mux_pready),
    .mux_prdata_i  (mux_prdata),
    .mux_pslverr_i (mux_pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    logic        slverr;
    logic [2:0]  sel;
    logic        err;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_psel"}, 32'(sl_psel), 0);
    chk({tag, "_sel"}, 32'(select), 0);
    chk({tag, "_penable"}, 32'(sl_penable), 0);
    chk({tag, "_pready"}, 32'(bus.m_pready_o), 0);
    chk({tag, "_prdata"}, bus.m_prdata_o, 0);
    chk({tag, "_pslverr"}, 32'(bus.m_pslverr_o), 0);
  endtask

  task automatic idle_master();
    bus.m_psel_i    = 1'b0;
    bus.m_penable_i = 1'b0;
    mux_pready      = 1'b0;
    mux_pslverr     = 1'b0;
    mux_prdata      = '0;
  endtask

  // Called just after a posedge; returns just after a posedge.
  task automatic run_vec(input vec_t v, input int k);
    string t;
    t = $sformatf("v%0d", k);
    bus.m_psel_i    = 1'b1;
    bus.m_penable_i = 1'b0;
    bus.m_paddr_i   = v.addr;
    bus.m_pwrite_i  = v.wr;
    bus.m_pwdata_i  = v.wdata;
    mux_pready      = 1'b0;
    @(negedge clk);
    chk({t, "_c0_psel"}, 32'(sl_psel), 0);
    chk({t, "_c0_pready"}, 32'(bus.m_pready_o), 0);
    @(posedge clk); #1;
    bus.m_penable_i = 1'b1;
    @(negedge clk);
    if (v.err) begin
      chk({t, "_de_pready"}, 32'(bus.m_pready_o), 1);
      chk({t, "_de_pslverr"}, 32'(bus.m_pslverr_o), 1);
      chk({t, "_de_prdata"}, bus.m_prdata_o, 0);
      chk({t, "_de_psel"}, 32'(sl_psel), 0);
    end else begin
      chk({t, "_su_psel"}, 32'(sl_psel), 32'(v.sel));
      chk({t, "_su_select"}, 32'(select), 32'(v.sel));
      chk({t, "_su_penable"}, 32'(sl_penable), 0);
      chk({t, "_su_pready"}, 32'(bus.m_pready_o), 0);
      chk({t, "_su_paddr"}, sl_paddr, v.addr);
      chk({t, "_su_pwrite"}, 32'(sl_pwrite), 32'(v.wr));
      chk({t, "_su_pwdata"}, sl_pwdata, v.wdata);
      for (int w = 0; w <= v.waits; w++) begin
        @(posedge clk); #1;
        mux_pready  = (w == v.waits);
        mux_prdata  = v.rdata;
        mux_pslverr = v.slverr;
        @(negedge clk);
        chk({t, "_ac_psel"}, 32'(sl_psel), 32'(v.sel));
        chk({t, "_ac_penable"}, 32'(sl_penable), 1);
        chk({t, "_ac_pready"}, 32'(bus.m_pready_o), 32'(w == v.waits));
        chk({t, "_ac_prdata"}, bus.m_prdata_o,
            (w == v.waits) ? v.rdata : 32'h0);
        chk({t, "_ac_pslverr"}, 32'(bus.m_pslverr_o),
            32'((w == v.waits) && v.slverr));
      end
    end
    @(posedge clk); #1;
    idle_master();
  endtask

  task automatic start_xfer(input logic [31:0] a);
    bus.m_psel_i    = 1'b1;
    bus.m_penable_i = 1'b0;
    bus.m_paddr_i   = a;
    bus.m_pwrite_i  = 1'b0;
    bus.m_pwdata_i  = '0;
    @(posedge clk); #1;
    bus.m_psel_i = 1'b0;
    @(negedge clk);
    chk("xfer_setup_penable", 32'(sl_penable), 0);
  endtask

  initial begin
    int ok;
    vec_t v0;
    tbl[0] = '{32'h1004, 1'b1, 32'hA5A5_1234, 0, 32'h0, 1'b0, 3'b010, 1'b0};
    tbl[1] = '{32'h2000, 1'b0, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 3'b100, 1'b0};
    tbl[2] = '{32'h3000, 1'b1, 32'h1357_9BDF, 0, 32'h0, 1'b0, 3'b000, 1'b1};
    tbl[3] = '{32'h0000, 1'b0, 32'h0, 1, 32'h1111_2222, 1'b1, 3'b001, 1'b0};
    tbl[4] = '{32'h2FFC, 1'b1, 32'hCAFE_0001, 0, 32'h0, 1'b0, 3'b100, 1'b0};
    tbl[5] = '{32'hFFFF_FFFC, 1'b0, 32'h0, 0, 32'h0, 1'b0, 3'b000, 1'b1};
    tbl[6] = '{32'h0FFF, 1'b0, 32'h0, 2, 32'h7777_0F0F, 1'b0, 3'b001, 1'b0};
    v0     = '{32'h0040, 1'b1, 32'h0BAD_CAFE, 0, 32'h0, 1'b0, 3'b001, 1'b0};

    bus.m_paddr_i  = '0;
    bus.m_pwrite_i = 1'b0;
    bus.m_pwdata_i = '0;
    idle_master();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("rst");
    chk("rst_paddr", sl_paddr, 0);
    chk("rst_pwdata", sl_pwdata, 0);
    chk("rst_pwrite", 32'(sl_pwrite), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back: each vector starts in the IDLE cycle after completion.
    foreach (tbl[i]) run_vec(tbl[i], i);

    // Master drops psel during SETUP; slave transfer still completes.
    start_xfer(32'h1008);
    chk("viol_setup_psel", 32'(sl_psel), 32'b010);
    @(posedge clk); #1;
    @(negedge clk);
    chk("viol_acc_penable", 32'(sl_penable), 1);
    @(posedge clk); #1;
    mux_pready = 1'b1;
    mux_prdata = 32'h0BAD_F00D;
    @(negedge clk);
    chk("viol_pready", 32'(bus.m_pready_o), 1);
    chk("viol_prdata", bus.m_prdata_o, 32'h0BAD_F00D);
    @(posedge clk); #1;
    idle_master();
    @(negedge clk);
    chk_zero("viol_idle");

`ifdef APB_DEC_TIMEOUT_EN
    @(posedge clk); #1;
    start_xfer(32'h1000);
    ok = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (sl_penable && !bus.m_pready_o && sl_psel == 3'b010) ok++;
    end
    chk("tout_access_cycles", ok, 16);
    @(negedge clk);
    chk("tout_pready", 32'(bus.m_pready_o), 1);
    chk("tout_pslverr", 32'(bus.m_pslverr_o), 1);
    chk("tout_prdata", bus.m_prdata_o, 0);
    chk("tout_psel", 32'(sl_psel), 0);
    chk("tout_penable", 32'(sl_penable), 0);
    @(negedge clk);
    chk_zero("tout_idle");

    @(posedge clk); #1;
    start_xfer(32'h1000);
    ok = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (sl_penable && !bus.m_pready_o) ok++;
    end
    chk("late_access_cycles", ok, 15);
    @(posedge clk); #1;
    mux_pready  = 1'b1;
    mux_pslverr = 1'b1;
    mux_prdata  = 32'h5A5A_A5A5;
    @(negedge clk);
    chk("late_pready", 32'(bus.m_pready_o), 1);
    chk("late_pslverr", 32'(bus.m_pslverr_o), 1);
    chk("late_prdata", bus.m_prdata_o, 32'h5A5A_A5A5);
    chk("late_psel", 32'(sl_psel), 32'b010);
    @(posedge clk); #1;
    idle_master();
    @(negedge clk);
    chk_zero("late_idle");
`endif

    // Hang in ACCESS, then abort with reset.
    @(posedge clk); #1;
    bus.m_pwrite_i = 1'b1;
    bus.m_pwdata_i = 32'h2468_ACE0;
    start_xfer(32'h2004);
    ok = 0;
`ifdef APB_DEC_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
`else
    for (int i = 0; i < 100; i++) begin
`endif
      @(negedge clk);
      if (sl_penable && !bus.m_pready_o && sl_psel == 3'b100) ok++;
    end
`ifdef APB_DEC_TIMEOUT_EN
    chk("hang_access_cycles", ok, 3);
`else
    chk("hang_access_cycles", ok, 100);
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_zero("abort");
    chk("abort_paddr", sl_paddr, 0);
    chk("abort_pwdata", sl_pwdata, 0);
    chk("abort_pwrite", 32'(sl_pwrite), 0);
    @(posedge clk); #1;
    run_vec(v0, 99);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
